memory_map_ctrl: RTL and testbench

MEMORY_MAP_CTRL -- requirements
Module: memory_map_ctrl

---
 rtl/memory_map_ctrl.sv | 108 ++++++++++
 tb/tb_memory_map_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/memory_map_ctrl.sv
// memory_map_ctrl: RAM + screen + keyboard FIFO word map with 1-cycle registered reads.
// Define MEMORY_MAP_CTRL_ERR_EN to build the sticky invalid-address err flag.
module memory_map_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 15,
    parameter int RAM_AW    = 14,
    parameter int SCR_AW    = 13,
    parameter int KBD_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic              kbd_pending,
    output logic              err
);
    localparam int PW = $clog2(KBD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] R     = 32'(1) << RAM_AW;
    localparam logic [31:0] S     = 32'(1) << SCR_AW;
    localparam logic [31:0] KBD_A = R + S;

    logic [DATA_W-1:0] ram_mem  [2**RAM_AW];
    logic [DATA_W-1:0] scr_mem  [2**SCR_AW];
    logic [DATA_W-1:0] fifo_mem [KBD_DEPTH];

    logic [31:0]       a;
    logic              ram_hit, scr_hit, kbd_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [DATA_W-1:0] out_q, out_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push, pop, empty;

    assign a       = 32'(address);
    assign ram_hit = a < R;
    assign scr_hit = (a >= R) && (a < KBD_A);
    assign kbd_hit = a == KBD_A;
    assign ram_idx = RAM_AW'(address);
    assign scr_idx = SCR_AW'(a - R);

    // Full blocks a push even when a pop lands in the same cycle.
    assign empty       = cnt_q == '0;
    assign kbd_ready   = cnt_q != CW'(KBD_DEPTH);
    assign kbd_pending = !empty;
    assign push        = kbd_valid && kbd_ready;
    assign pop         = load && kbd_hit && !empty;

    always_comb begin
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(pop);
        out_d = ram_hit            ? ram_mem[ram_idx] :
                scr_hit            ? scr_mem[scr_idx] :
                (kbd_hit && !empty) ? fifo_mem[rd_q]  : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // Storage arrays carry no reset; writes are simply suppressed during reset.
    always_ff @(posedge CLK) begin
        if (RST_N && load && ram_hit)
            ram_mem[ram_idx] <= in;
    end

    always_ff @(posedge CLK) begin
        if (RST_N && load && scr_hit)
            scr_mem[scr_idx] <= in;
    end

    always_ff @(posedge CLK) begin
        if (RST_N && push)
            fifo_mem[wr_q] <= kbd_data;
    end

    assign out = out_q;

`ifdef MEMORY_MAP_CTRL_ERR_EN
    logic err_q;
    always_ff @(posedge CLK) begin
        if (!RST_N)
            err_q <= 1'b0;
        else if (a > KBD_A)
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_memory_map_ctrl.sv
// tb_memory_map_ctrl: table-driven directed vectors plus a FIFO wrap sequence.
module tb_memory_map_ctrl;
`ifdef MEMORY_MAP_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic [14:0] address = '0;
    logic [15:0] out;
    logic [15:0] kbd_data = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready, kbd_pending, err;

    memory_map_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .in(in), .load(load), .address(address), .out(out),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .kbd_pending(kbd_pending), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n, ld, vld;
        logic [15:0] din;
        logic [14:0] addr;
        logic [15:0] kbd;
        bit          chk;
        logic [15:0] exp_out;
        logic        exp_rdy, exp_pend, exp_err;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total = 0;

    function automatic void add(logic rn, logic ld, logic vl, logic [15:0] din, int adr,
                                logic [15:0] kbd, bit chk, logic [15:0] eo,
                                logic er, logic ep, logic ee);
        vec_t v;
        v.rst_n = rn; v.ld = ld; v.vld = vl; v.din = din; v.addr = 15'(adr); v.kbd = kbd;
        v.chk = chk; v.exp_out = eo; v.exp_rdy = er; v.exp_pend = ep; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want)
            $display("FAIL %s: got %h want %h", name, got, want);
        else
            passed++;
    endtask

    task automatic drive(logic rn, logic ld, logic vl, logic [15:0] din, logic [14:0] adr,
                         logic [15:0] kbd);
        RST_N = rn; load = ld; kbd_valid = vl; in = din; address = adr; kbd_data = kbd;
        @(posedge CLK);
        #1;
    endtask

    localparam int K = 24576;

    initial begin
        // rst ld vld din addr kbd chk out rdy pend err
        add(0, 0, 0, 16'h0000, 0,     0, 1, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h1234, 5,     0, 0, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h00AA, 0,     0, 0, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h0000, 16384, 0, 0, 16'h0000, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 5,     0, 1, 16'h1234, 1, 0, 0);
        add(1, 1, 0, 16'hBEEF, 16384, 0, 1, 16'h0000, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 16384, 0, 1, 16'hBEEF, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 0,     0, 1, 16'h00AA, 1, 0, 0);
        add(1, 1, 0, 16'h1111, 6,     0, 0, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h2222, 6,     0, 1, 16'h1111, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 6,     0, 1, 16'h2222, 1, 0, 0);
        add(1, 1, 0, 16'h7777, 16383, 0, 0, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h8888, 24575, 0, 0, 16'h0000, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 16383, 0, 1, 16'h7777, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 24575, 0, 1, 16'h8888, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 16384, 0, 1, 16'hBEEF, 1, 0, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0000, 1, 0, 0);
        add(1, 0, 1, 16'h0000, 0, 16'h41, 1, 16'h00AA, 1, 1, 0);
        add(1, 0, 1, 16'h0000, 0, 16'h42, 1, 16'h00AA, 1, 1, 0);
        add(1, 0, 1, 16'h0000, 0, 16'h43, 1, 16'h00AA, 1, 1, 0);
        add(1, 0, 1, 16'h0000, 0, 16'h44, 1, 16'h00AA, 0, 1, 0);
        add(1, 0, 1, 16'h0000, K, 16'h45, 1, 16'h0041, 0, 1, 0);
        add(1, 1, 0, 16'hFFFF, K, 16'h00, 1, 16'h0041, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0042, 1, 1, 0);
        add(1, 0, 1, 16'h0000, K, 16'h45, 1, 16'h0042, 0, 1, 0);
        add(1, 1, 1, 16'h0000, K, 16'h46, 1, 16'h0042, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0043, 1, 1, 0);
        add(1, 1, 1, 16'h0000, K, 16'h55, 1, 16'h0043, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0044, 1, 1, 0);
        add(1, 1, 0, 16'h0000, K, 16'h00, 1, 16'h0044, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0045, 1, 1, 0);
        add(1, 1, 0, 16'h0000, K, 16'h00, 1, 16'h0045, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0055, 1, 1, 0);
        add(1, 1, 0, 16'h0000, K, 16'h00, 1, 16'h0055, 1, 0, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0000, 1, 0, 0);
        add(1, 1, 0, 16'h0000, K, 16'h00, 1, 16'h0000, 1, 0, 0);
        add(1, 1, 1, 16'h0000, K, 16'h66, 1, 16'h0000, 1, 1, 0);
        add(1, 0, 0, 16'h0000, K, 16'h00, 1, 16'h0066, 1, 1, 0);
        add(1, 1, 0, 16'h0000, K, 16'h00, 1, 16'h0066, 1, 0, 0);
        add(1, 0, 0, 16'h0000, K + 1, 0,  1, 16'h0000, 1, 0, 1);
        add(1, 0, 0, 16'h0000, 5,     0,  1, 16'h1234, 1, 0, 1);
        add(1, 1, 0, 16'hDEAD, 30000, 0,  1, 16'h0000, 1, 0, 1);
        add(1, 0, 0, 16'h0000, 32767, 0,  1, 16'h0000, 1, 0, 1);
        add(0, 1, 1, 16'h0000, K, 16'h77, 1, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'hFFFF, 5,     0,  1, 16'h0000, 1, 0, 0);
        add(1, 0, 0, 16'h0000, 5,     0,  1, 16'h1234, 1, 0, 0);
        add(1, 0, 0, 16'h0000, K,     0,  1, 16'h0000, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].ld, vecs[i].vld, vecs[i].din, vecs[i].addr, vecs[i].kbd);
            if (vecs[i].chk)
                check($sformatf("v%0d out", i), out, vecs[i].exp_out);
            check($sformatf("v%0d kbd_ready", i), 16'(kbd_ready), 16'(vecs[i].exp_rdy));
            check($sformatf("v%0d kbd_pending", i), 16'(kbd_pending), 16'(vecs[i].exp_pend));
            check($sformatf("v%0d err", i), 16'(err), 16'(vecs[i].exp_err & ERR_EN));
        end

        // Keep two entries queued and push+pop repeatedly so both pointers wrap.
        drive(1, 0, 1, 16'h0000, 15'd0, 16'h0100);
        drive(1, 0, 1, 16'h0000, 15'd0, 16'h0101);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 16'h0000, 15'(K), 16'(16'h0102 + i));
            check($sformatf("wrap%0d out", i), out, 16'(16'h0100 + i));
            check($sformatf("wrap%0d pending", i), 16'(kbd_pending), 16'd1);
            check($sformatf("wrap%0d ready", i), 16'(kbd_ready), 16'd1);
        end
        drive(1, 0, 0, 16'h0000, 15'(K), 16'h0000);
        check("wrap head", out, 16'h010A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
